// File: rtl/shift_register_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared constants for the shift register sequencer.
//   - Command opcodes carried on CMD_OP.
//   - Register mux select codes driven on {S1,S0}.
//   - FSM state encoding.
//   - Helper that maps a rotate opcode to its select code.
package shift_register_sequencer_pkg;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ROTL = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] SEL_ROTL = 2'b00;
  localparam logic [1:0] SEL_ROTR = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Any rotate opcode other than ROTR rotates left; only called from SHIFT.
  function automatic logic [1:0] shift_sel(input logic [1:0] op);
    return (op == OP_ROTR) ? SEL_ROTR : SEL_ROTL;
  endfunction

endpackage

// File: rtl/shift_register_sequencer_count.sv
`timescale 1ns/1ps
// shift_count_down: loadable down-counter tracking the remaining rotate edges.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (count -> 0)
//   load      - load load_val (takes priority over en)
//   load_val  - rotate count to load
//   en        - decrement this cycle (saturates at 0)
//   last      - count == 1, i.e. the current cycle is the final rotate
module shift_count_down
  import shift_register_sequencer_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shift_register_sequencer.sv
`timescale 1ns/1ps
// shift_register_sequencer: command-driven controller for a WIDTH-bit
// bidirectional shift register (per-bit 4:1 mux + DFF).
// Ports:
//   CLK, RST     - clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY - command handshake
//   CMD_OP       - 00 READ, 01 LOAD, 10 ROTL, 11 ROTR
//   CMD_COUNT    - rotate count (rotates only)
//   CMD_DATA     - load value (LOAD only)
//   S1, S0       - register mux select
//   D            - register parallel-load data
//   Q            - register contents fed back
//   DONE         - one-cycle completion pulse
//   RESULT       - register value captured at completion
//   BUSY         - state is not IDLE
//
// state   | meaning
// IDLE    | ready for a command, register held
// LOAD    | select parallel load for one cycle
// SHIFT   | rotate one position per cycle until the counter expires
// CAPTURE | register held, RESULT takes Q on the exiting edge
// DONE    | DONE pulse, back to IDLE
module shift_register_sequencer
  import shift_register_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic             S1,
  output logic             S0,
  output logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY
);

  state_t     state;
  logic [1:0] op_q;
  logic       ready_en;
  logic       accept;
  logic       is_rot;
  logic       cnt_load;
  logic       cnt_last;
  logic [1:0] sel;

  assign accept   = CMD_VALID && CMD_READY;
  assign is_rot   = (CMD_OP == OP_ROTL) || (CMD_OP == OP_ROTR);
  assign cnt_load = accept && is_rot && (CMD_COUNT != '0);

  shift_count_down #(.CNT_W(CNT_W)) u_count (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (CMD_COUNT),
    .en       (state == ST_SHIFT),
    .last     (cnt_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      op_q     <= OP_READ;
      ready_en <= 1'b0;
      D        <= '0;
      RESULT   <= '0;
    end else begin
      // READY stays low until the first edge after reset release.
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= CMD_OP;
            if (CMD_OP == OP_LOAD) begin
              D     <= CMD_DATA;
              state <= ST_LOAD;
            end else if (cnt_load) begin
              state <= ST_SHIFT;
            end else begin
              state <= ST_CAPTURE;
            end
          end
        end
        ST_LOAD:  state <= ST_CAPTURE;
        ST_SHIFT: begin
          if (cnt_last) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          RESULT <= Q;
          state  <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from the state register so an async reset drops the
  // select to hold in the same instant.
  always_comb begin
    sel = SEL_HOLD;
    case (state)
      ST_LOAD:  sel = SEL_LOAD;
      ST_SHIFT: sel = shift_sel(op_q);
      default:  sel = SEL_HOLD;
    endcase
  end

  assign S1        = sel[1];
  assign S0        = sel[0];
  assign CMD_READY = (state == ST_IDLE) && ready_en;
  assign DONE      = (state == ST_DONE);
  assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_register_sequencer.sv
`timescale 1ns/1ps
module tb_shift_register_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic [2:0] CMD_COUNT = 3'd0;
  logic [3:0] CMD_DATA = 4'd0;
  logic       S1, S0;
  logic [3:0] D;
  logic [3:0] Q;
  logic       DONE;
  logic [3:0] RESULT;
  logic       BUSY;

  logic [3:0] q_reg = 4'b0000;

  int checks = 0;
  int errors = 0;

  int lat, n_ld, n_rl, n_rr, waits;
  bit rdy_busy;
  bit done_seen;

  always #5 CLK = ~CLK;

  shift_register_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_COUNT (CMD_COUNT),
    .CMD_DATA  (CMD_DATA),
    .S1        (S1),
    .S0        (S0),
    .D         (D),
    .Q         (Q),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .BUSY      (BUSY)
  );

  // Behavioural model of the 4-bit bidirectional shift register.
  always_ff @(posedge CLK) begin
    case ({S1, S0})
      2'b00:   q_reg <= {q_reg[2:0], q_reg[3]};
      2'b01:   q_reg <= {q_reg[0], q_reg[3:1]};
      2'b11:   q_reg <= D;
      default: q_reg <= q_reg;
    endcase
  end
  assign Q = q_reg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Presents a command, waits (bounded) for acceptance,
  // then counts cycles after the accept edge until DONE is seen.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input bit hold_valid, input bit scramble,
                         output int lat_o, output int ld_o, output int rl_o, output int rr_o,
                         output int wait_o, output bit rdy_o);
    lat_o = 0; ld_o = 0; rl_o = 0; rr_o = 0; wait_o = 0; rdy_o = 1'b0;
    CMD_OP = op; CMD_COUNT = cnt; CMD_DATA = data; CMD_VALID = 1'b1;
    while (!CMD_READY && wait_o < 50) begin
      @(negedge CLK);
      wait_o++;
    end
    @(posedge CLK);
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (scramble) begin
        CMD_OP   = 2'b01;
        CMD_DATA = 4'($urandom_range(0, 15));
      end else if (!hold_valid) begin
        CMD_VALID = 1'b0;
      end
      if (CMD_READY) rdy_o = 1'b1;
      case ({S1, S0})
        2'b11: ld_o++;
        2'b00: rl_o++;
        2'b01: rr_o++;
        default: ;
      endcase
      if (DONE) begin
        lat_o = c;
        break;
      end
    end
    if (scramble) CMD_VALID = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_sel", {S1, S0}, 2'b10);
    chk("rst_d", D, 4'h0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_result", RESULT, 4'h0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ready", CMD_READY, 1'b0);
    RST = 1'b0;
    #1 chk("ready_before_edge", CMD_READY, 1'b0);
    @(negedge CLK);
    chk("ready_after_edge", CMD_READY, 1'b1);

    // LOAD 1011
    run_cmd(2'b01, 3'd0, 4'b1011, 1'b0, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("load_lat", lat, 3);
    chk("load_sel_cycles", n_ld, 1);
    chk("load_rot_cycles", n_rl + n_rr, 0);
    chk("load_result", RESULT, 4'b1011);
    chk("load_q", Q, 4'b1011);
    chk("load_d", D, 4'b1011);

    // ROTL 1 -> 0111
    run_cmd(2'b10, 3'd1, 4'hf, 1'b0, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("rotl1_lat", lat, 3);
    chk("rotl1_cycles", n_rl, 1);
    chk("rotl1_result", RESULT, 4'b0111);

    // ROTR 2 -> 1101
    run_cmd(2'b11, 3'd2, 4'h0, 1'b0, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("rotr2_lat", lat, 4);
    chk("rotr2_cycles", n_rr, 2);
    chk("rotr2_other", n_rl + n_ld, 0);
    chk("rotr2_result", RESULT, 4'b1101);

    // ROTL 0 -> no shift cycles
    run_cmd(2'b10, 3'd0, 4'h0, 1'b0, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("rotl0_lat", lat, 2);
    chk("rotl0_cycles", n_rl + n_rr + n_ld, 0);
    chk("rotl0_result", RESULT, 4'b1101);

    // READ
    run_cmd(2'b00, 3'd5, 4'h3, 1'b0, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("read_lat", lat, 2);
    chk("read_cycles", n_rl + n_rr + n_ld, 0);
    chk("read_result", RESULT, 4'b1101);

    // ROTR 4 wraps to original
    run_cmd(2'b11, 3'd4, 4'h0, 1'b0, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("rotr4_lat", lat, 6);
    chk("rotr4_cycles", n_rr, 4);
    chk("rotr4_result", RESULT, 4'b1101);

    // ROTL 1 with VALID held and data/op scrambled while busy
    run_cmd(2'b10, 3'd1, 4'h6, 1'b1, 1'b1, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("busy_lat", lat, 3);
    chk("busy_ready_low", rdy_busy, 1'b0);
    chk("busy_no_load", n_ld, 0);
    chk("busy_d_unchanged", D, 4'b1011);
    chk("busy_result", RESULT, 4'b1011);
    @(negedge CLK);
    chk("done_one_cycle", DONE, 1'b0);
    chk("idle_after_done", BUSY, 1'b0);

    // Reset in the middle of ROTL 7
    CMD_OP = 2'b10; CMD_COUNT = 3'd7; CMD_DATA = 4'h0; CMD_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_busy", BUSY, 1'b1);
    chk("mid_sel_rotl", {S1, S0}, 2'b00);
    #2 RST = 1'b1;
    #1;
    chk("abort_sel_hold", {S1, S0}, 2'b10);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_result", RESULT, 4'h0);
    chk("abort_ready", CMD_READY, 1'b0);
    done_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (DONE) done_seen = 1'b1;
    end
    RST = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (DONE) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 1'b0);
    chk("abort_ready_after", CMD_READY, 1'b1);

    // LOAD 0001 after abort
    run_cmd(2'b01, 3'd0, 4'b0001, 1'b0, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("reload_lat", lat, 3);
    chk("reload_result", RESULT, 4'b0001);

    // Back-to-back LOAD 1000 then ROTR 3 with VALID held
    run_cmd(2'b01, 3'd0, 4'b1000, 1'b1, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("b2b_load_lat", lat, 3);
    chk("b2b_load_result", RESULT, 4'b1000);
    run_cmd(2'b11, 3'd3, 4'h0, 1'b0, 1'b0, lat, n_ld, n_rl, n_rr, waits, rdy_busy);
    chk("b2b_accept_wait", waits, 1);
    chk("b2b_rotr_lat", lat, 5);
    chk("b2b_rotr_cycles", n_rr, 3);
    chk("b2b_result", RESULT, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register_sequencer.md
Name: shift_register_sequencer

Overview:
- Command-driven controller for the 4-bit bidirectional shift register, i.e. the register with a per-bit 4:1 mux and edge-triggered DFF.
- Accepts one command at a time over a valid/ready handshake: parallel load, rotate left N, rotate right N, or read.
- Drives the register's S1/S0 select and D inputs cycle by cycle, then returns the final register contents with a one-cycle DONE pulse.
- Sits between a host/test harness and the register instance; Q is fed back for result capture.

Parameters:
- WIDTH, 4, register width; all data ports are WIDTH bits.
- CNT_W, 3, width of the rotate-count field; counts 0..2^CNT_W-1.

Ports:
- CLK  input  1  clock; the register shares the same CLK.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  sequencer can accept a command.
- CMD_OP  input  2  00 READ, 01 LOAD, 10 ROTL, 11 ROTR.
- CMD_COUNT  input  CNT_W  rotate count; ignored for READ/LOAD.
- CMD_DATA  input  WIDTH  load value; ignored unless LOAD.
- S1  output  1  register mux select MSB.
- S0  output  1  register mux select LSB.
- D  output  WIDTH  register parallel-load data.
- Q  input  WIDTH  register outputs (Q[WIDTH-1] = Q3).
- DONE  output  1  one-cycle completion pulse.
- RESULT  output  WIDTH  register value captured at completion.
- BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: single clock CLK. RST is asynchronous, active-high.
- Select encoding {S1,S0}:
  - 00 rotate left: Q[i]<=Q[i-1], Q0<=Q3.
  - 01 rotate right: Q[i]<=Q[i+1], Q3<=Q0.
  - 10 hold.
  - 11 parallel load from D.
- Reset values while RST is high: state IDLE, {S1,S0}=10 (hold), D=0, DONE=0, RESULT=0, BUSY=0, CMD_READY=0. After release, CMD_READY=1 from the first clock edge.
- RST mid-operation aborts immediately:
  - S forced to hold the same instant.
  - Register contents are whatever the last completed edge left; no completion is reported.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, DONE. Outputs are Moore, decoded from registered state.
- IDLE:
  - CMD_READY=1, S=hold.
  - On CMD_VALID&&CMD_READY, latch op/count/data. D takes the latched data from the next cycle and holds it until the next LOAD accept.
  - Next state: LOAD→LOAD; ROTL/ROTR with count≠0 → SHIFT (counter=count); ROTL/ROTR with count=0 or READ → CAPTURE.
- LOAD: S=11 for exactly one cycle, then CAPTURE.
- SHIFT:
  - S=00 (ROTL) or 01 (ROTR); the counter decrements every cycle.
  - When counter==1, the next state is CAPTURE. The register therefore sees exactly count rotate edges.
- CAPTURE: S=hold; RESULT<=Q on the exiting edge.
- DONE: S=hold, DONE=1 for one cycle, RESULT valid; next state IDLE.
- RESULT holds its value until the next CAPTURE.
- Latency from accept edge to DONE high:
  - LOAD: 3 cycles.
  - READ / zero-count rotate: 2 cycles.
  - Rotate N: N+2 cycles.
- Back-to-back: the earliest next accept is the cycle after DONE, since CMD_READY is 0 during DONE.
- Counts ≥ WIDTH are legal; rotation wraps modulo WIDTH naturally (count 4 on WIDTH=4 returns the original value).
- CMD_VALID while not ready is ignored; there is no queueing. The host holds the command until it is accepted.
- S1/S0 are never 11 outside LOAD and never a rotate value outside SHIFT. The register holds in all other states.

Decomposition:
- Shared package holds:
  - Opcode constants OP_READ/OP_LOAD/OP_ROTL/OP_ROTR.
  - Select constants SEL_ROTL=2'b00, SEL_ROTR=2'b01, SEL_HOLD=2'b10, SEL_LOAD=2'b11.
  - State encoding constants.
- One natural sub-module: shift_count_down, a loadable CNT_W down-counter with a last-cycle flag. Async reset to 0.
- The top level holds the FSM, command latches and output decode.
- Bench instantiates the sequencer with the existing register module (WIDTH=4).

Test Plan:
- Reset then LOAD 4'b1011 → S=11 exactly one cycle; DONE 3 cycles after accept; RESULT=4'b1011; Q=1011.
- After load 1011, ROTL count 1 → one S=00 cycle, RESULT=4'b0111. ROTR count 2 from 0111 → two S=01 cycles, RESULT=4'b1101.
- ROTL count 0 and READ → no shift-select cycles, DONE 2 cycles after accept, RESULT=current Q. ROTR count 4 on 1101 → RESULT=1101, DONE after 6 cycles.
- CMD_VALID held during BUSY with changing CMD_DATA → only the accepted command executes; CMD_READY=0 until IDLE; D unchanged.
- RST asserted asynchronously in the middle of ROTL count 7 → S=10 immediately; DONE never pulses; BUSY=0; RESULT=0. New LOAD 4'b0001 after release completes normally.
- Back-to-back LOAD 4'b1000 then ROTR count 3 with VALID held continuously → second accept the cycle after DONE; RESULT=4'b0001.
